// File: rtl/tfmbs_axi_readback.sv
// rtl/tfmbs_axi_readback.sv - AXI4-Lite read responder serving lane accumulator snapshots and status.
// Optional FRAME_COUNT register enabled by TFMBS_READBACK_FRAME_COUNT_EN.
module tfmbs_axi_readback #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    input  logic [LANES*32-1:0]     vector_results,
    input  logic                    frame_done,
    output logic                    snap_valid
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic                  arready_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  snap_valid_q;
    logic                  overrun_q;
    logic [DATA_WIDTH-1:0] snap_bank [LANES];

    logic [5:0]            reg_idx;
    logic                  upper_zero;
    logic                  ar_accept;
    logic                  status_read;
    logic                  consume_last;
    logic                  capture;
    logic                  overrun_set;
    logic [DATA_WIDTH-1:0] dec_data;
    logic [1:0]            dec_resp;
    logic [1:0]            unused_addr_lsb;

    assign unused_addr_lsb = s_axi_araddr[1:0];

    assign reg_idx    = s_axi_araddr[7:2];
    assign upper_zero = (s_axi_araddr[ADDR_WIDTH-1:8] == '0);
    assign ar_accept  = arready_q && s_axi_arvalid;

    assign status_read  = ar_accept && upper_zero && (reg_idx == 6'd0);
    assign consume_last = ar_accept && upper_zero && (reg_idx == 6'(LANES + 3));

    // A consuming read of the last lane frees the bank in the same cycle, so a
    // coincident frame_done captures instead of overrunning.
    assign capture     = frame_done && (!snap_valid_q || consume_last);
    assign overrun_set = frame_done && snap_valid_q && !consume_last;

`ifdef TFMBS_READBACK_FRAME_COUNT_EN
    logic [31:0] frame_count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_count_q <= '0;
        end else if (capture) begin
            frame_count_q <= frame_count_q + 32'd1;
        end
    end
`endif

    always_comb begin
        dec_data = '0;
        dec_resp = RESP_SLVERR;
        if (upper_zero) begin
            if (reg_idx == 6'd0) begin
                dec_data = {{(DATA_WIDTH-2){1'b0}}, overrun_q, snap_valid_q};
                dec_resp = RESP_OKAY;
            end
`ifdef TFMBS_READBACK_FRAME_COUNT_EN
            if (reg_idx == 6'd1) begin
                dec_data = DATA_WIDTH'(frame_count_q);
                dec_resp = RESP_OKAY;
            end
`endif
            for (int k = 0; k < LANES; k++) begin
                if (reg_idx == 6'(k + 4)) begin
                    dec_data = snap_bank[k];
                    dec_resp = RESP_OKAY;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ar_accept) state_d = RESP;
            RESP: if (s_axi_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            arready_q <= (state_d == IDLE);
            rvalid_q  <= (state_d == RESP);
            if (ar_accept) begin
                rdata_q <= dec_data;
                rresp_q <= dec_resp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            snap_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                snap_bank[k] <= '0;
            end
        end else begin
            if (capture) begin
                snap_valid_q <= 1'b1;
                for (int k = 0; k < LANES; k++) begin
                    snap_bank[k] <= DATA_WIDTH'(vector_results[k*32 +: 32]);
                end
            end else if (consume_last) begin
                snap_valid_q <= 1'b0;
            end

            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (status_read) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign snap_valid    = snap_valid_q;

endmodule

// File: tb/tb_tfmbs_axi_readback.sv
// tb/tb_tfmbs_axi_readback.sv - directed self-checking bench for tfmbs_axi_readback.
module tb_tfmbs_axi_readback;

    localparam int LANES = 15;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [31:0]          araddr;
    logic                 arvalid;
    logic                 arready;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;
    logic [LANES*32-1:0]  vector_results;
    logic                 frame_done;
    logic                 snap_valid;

    int total = 0;
    int bad   = 0;

    tfmbs_axi_readback #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .LANES(LANES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .s_axi_araddr(araddr),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata(rdata),
        .s_axi_rresp(rresp),
        .s_axi_rvalid(rvalid),
        .s_axi_rready(rready),
        .vector_results(vector_results),
        .frame_done(frame_done),
        .snap_valid(snap_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic set_lanes(input logic [31:0] base);
        for (int k = 0; k < LANES; k++) begin
            vector_results[k*32 +: 32] = base + 32'(k);
        end
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    // fd=1 raises frame_done in the AR acceptance cycle (caller ensures arready is high)
    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                      input logic [1:0] exp_resp, input bit fd);
        int n;
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        frame_done = fd;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk({tag, "_arready_timeout"}, 32'(arready), 32'd1);
        end
        @(posedge clk);
        #1;
        arvalid    = 1'b0;
        frame_done = 1'b0;
        chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, "_arready_low"}, 32'(arready), 32'd0);
        chk({tag, "_rdata"}, rdata, exp_data);
        chk({tag, "_rresp"}, 32'(rresp), 32'(exp_resp));
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
        chk({tag, "_rvalid_drop"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        araddr         = '0;
        arvalid        = 1'b0;
        rready         = 1'b0;
        frame_done     = 1'b0;
        vector_results = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_snap_valid", 32'(snap_valid), 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_arready", 32'(arready), 32'd1);

        rd("status0", 32'h00, 32'h0, OKAY, 1'b0);

        // single frame, walk all lanes
        set_lanes(32'h1000);
        pulse_frame();
        chk("f1_snap_valid", 32'(snap_valid), 32'd1);
        for (int k = 0; k < LANES - 1; k++) begin
            rd("f1_lane", 32'h10 + 32'(4*k), 32'h1000 + 32'(k), OKAY, 1'b0);
            chk("f1_snap_held", 32'(snap_valid), 32'd1);
        end
        rd("f1_last", 32'h48, 32'h100E, OKAY, 1'b0);
        chk("f1_snap_clr", 32'(snap_valid), 32'd0);
`ifdef TFMBS_READBACK_FRAME_COUNT_EN
        rd("fc1", 32'h04, 32'd1, OKAY, 1'b0);
`else
        rd("fc1_off", 32'h04, 32'd0, SLVERR, 1'b0);
`endif

        // overrun: second frame is dropped
        set_lanes(32'h2000);
        pulse_frame();
        set_lanes(32'h3000);
        pulse_frame();
        rd("ovr_status", 32'h00, 32'h3, OKAY, 1'b0);
        rd("ovr_status2", 32'h00, 32'h1, OKAY, 1'b0);
        rd("ovr_lane0", 32'h10, 32'h2000, OKAY, 1'b0);
        rd("ovr_last", 32'h48, 32'h200E, OKAY, 1'b0);

        // unmapped addresses
        set_lanes(32'h4000);
        pulse_frame();
        rd("err_4c", 32'h4C, 32'h0, SLVERR, 1'b0);
        rd("err_100", 32'h100, 32'h0, SLVERR, 1'b0);
        rd("err_08", 32'h08, 32'h0, SLVERR, 1'b0);
        chk("err_snap_valid", 32'(snap_valid), 32'd1);

        // stalled R channel while a new frame is captured
        @(negedge clk);
        araddr  = 32'h48;
        arvalid = 1'b1;
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        chk("stall_rvalid", 32'(rvalid), 32'd1);
        chk("stall_rdata0", rdata, 32'h400E);
        chk("stall_snap_clr", 32'(snap_valid), 32'd0);
        set_lanes(32'h5000);
        pulse_frame();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_rdata", rdata, 32'h400E);
            chk("stall_rvalid_held", 32'(rvalid), 32'd1);
        end
        chk("stall_snap_new", 32'(snap_valid), 32'd1);
        @(negedge clk);
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
        chk("stall_done", 32'(rvalid), 32'd0);
        rd("stall_lane0", 32'h10, 32'h5000, OKAY, 1'b0);
        rd("stall_last", 32'h48, 32'h500E, OKAY, 1'b0);

        // frame_done coincident with consuming last-lane read
        set_lanes(32'h6000);
        pulse_frame();
        set_lanes(32'h7000);
        rd("sim_last", 32'h48, 32'h600E, OKAY, 1'b1);
        chk("sim_snap_valid", 32'(snap_valid), 32'd1);
        rd("sim_status", 32'h00, 32'h1, OKAY, 1'b0);
        rd("sim_lane0", 32'h10, 32'h7000, OKAY, 1'b0);
        rd("sim_last2", 32'h48, 32'h700E, OKAY, 1'b0);

        // overrun set wins over STATUS read clear
        pulse_frame();
        rd("ovr_win_read", 32'h00, 32'h1, OKAY, 1'b1);
        rd("ovr_win_after", 32'h00, 32'h3, OKAY, 1'b0);
        rd("ovr_win_clr", 32'h00, 32'h1, OKAY, 1'b0);

        // STATUS read in the capture cycle sees pre-capture value
        rd("pre_drain", 32'h48, 32'h700E, OKAY, 1'b0);
        rd("pre_status", 32'h00, 32'h0, OKAY, 1'b1);
        chk("pre_snap_valid", 32'(snap_valid), 32'd1);
        rd("post_status", 32'h00, 32'h1, OKAY, 1'b0);
`ifdef TFMBS_READBACK_FRAME_COUNT_EN
        rd("fc_final", 32'h04, 32'd8, OKAY, 1'b0);
`else
        rd("fc_final_off", 32'h04, 32'd0, SLVERR, 1'b0);
`endif

        // reset while a response is pending
        @(negedge clk);
        araddr  = 32'h10;
        arvalid = 1'b1;
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        chk("rr_rvalid", 32'(rvalid), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rr_rvalid_drop", 32'(rvalid), 32'd0);
        chk("rr_arready", 32'(arready), 32'd0);
        chk("rr_snap_valid", 32'(snap_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd("rr_lane0", 32'h10, 32'h0, OKAY, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
